// File: rtl/l2cache_req_arbiter.sv
// Arbitrates the icache and dcache onto the single L2 request port.
// One transaction in flight; dcache has priority, bounded by a starvation counter.
module l2cache_req_arbiter #(
  parameter int addr_width   = 32,
  parameter int data_width   = 32,
  parameter int starve_limit = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_req,
  input  logic [addr_width-1:0] icache_addr,
  output logic                  icache_addrOK,
  output logic                  icache_dataOK,
  output logic [data_width-1:0] icache_rdata,
  input  logic                  dcache_req,
  input  logic                  dcache_we,
  input  logic                  dcache_SUC,
  input  logic [addr_width-1:0] dcache_addr,
  input  logic [data_width-1:0] dcache_wdata,
  input  logic [3:0]            dcache_wstrb,
  output logic                  dcache_addrOK,
  output logic                  dcache_dataOK,
  output logic [data_width-1:0] dcache_rdata,
  output logic [1:0]            arb_from,
  output logic [addr_width-1:0] arb_addr,
  output logic [data_width-1:0] arb_wdata,
  output logic [3:0]            arb_wstrb,
  output logic                  arb_SUC,
  input  logic                  l2_icache_addrOK,
  input  logic                  l2_icache_dataOK,
  input  logic                  l2_dcache_addrOK,
  input  logic                  l2_dcache_dataOK,
  input  logic [data_width-1:0] l2_rdata,
  output logic                  arb_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_D} state_t;

  localparam logic [3:0] LIMIT = 4'(starve_limit);

  state_t                state;
  logic [3:0]            starve_cnt;
  logic [1:0]            hold_from;
  logic [addr_width-1:0] hold_addr;
  logic [data_width-1:0] hold_wdata;
  logic [3:0]            hold_wstrb;
  logic                  hold_suc;

  logic i_win, d_win, i_side, acc, done, proto_err;

  // Grant is purely combinational so the winner sees addrOK in the request cycle.
  always_comb begin
    i_win = 1'b0;
    d_win = 1'b0;
    if (!rst && state == IDLE) begin
      i_win = icache_req && (!dcache_req || starve_cnt == LIMIT);
      d_win = dcache_req && !i_win;
    end
  end

  assign icache_addrOK = i_win;
  assign dcache_addrOK = d_win;

  assign i_side = (hold_from == 2'b01);
  assign acc    = (state == ISSUE)  && (i_side ? l2_icache_addrOK : l2_dcache_addrOK);
  assign done   = (state == WAIT_D) && (i_side ? l2_icache_dataOK : l2_dcache_dataOK);

  always_comb begin
    proto_err = 1'b0;
    case (state)
      IDLE:    proto_err = l2_icache_addrOK | l2_dcache_addrOK | l2_icache_dataOK | l2_dcache_dataOK;
      ISSUE:   proto_err = l2_icache_dataOK | l2_dcache_dataOK |
                           (i_side ? l2_dcache_addrOK : l2_icache_addrOK);
      WAIT_D:  proto_err = l2_icache_addrOK | l2_dcache_addrOK |
                           (i_side ? l2_dcache_dataOK : l2_icache_dataOK);
      default: proto_err = 1'b0;
    endcase
  end

  assign arb_from  = (state == ISSUE) ? hold_from : 2'b00;
  assign arb_addr  = hold_addr;
  assign arb_wdata = hold_wdata;
  assign arb_wstrb = hold_wstrb;
  assign arb_SUC   = hold_suc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      hold_from     <= '0;
      hold_addr     <= '0;
      hold_wdata    <= '0;
      hold_wstrb    <= '0;
      hold_suc      <= 1'b0;
      icache_dataOK <= 1'b0;
      dcache_dataOK <= 1'b0;
      icache_rdata  <= '0;
      dcache_rdata  <= '0;
      arb_err       <= 1'b0;
    end else begin
      icache_dataOK <= 1'b0;
      dcache_dataOK <= 1'b0;
      if (proto_err) arb_err <= 1'b1;
      case (state)
        IDLE: if (i_win || d_win) begin
          hold_from  <= i_win ? 2'b01 : (dcache_we ? 2'b11 : 2'b10);
          hold_addr  <= i_win ? icache_addr : dcache_addr;
          hold_wdata <= i_win ? '0 : dcache_wdata;
          hold_wstrb <= i_win ? '0 : dcache_wstrb;
          hold_suc   <= i_win ? 1'b0 : dcache_SUC;
          if (i_win)
            starve_cnt <= '0;
          else if (icache_req && starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 4'd1;
          state <= ISSUE;
        end
        ISSUE: if (acc) begin
          // Writes have no data phase: complete as soon as L2 takes them.
          if (hold_from == 2'b11) begin
            dcache_dataOK <= 1'b1;
            state         <= IDLE;
          end else begin
            state <= WAIT_D;
          end
        end
        WAIT_D: if (done) begin
          if (i_side) begin
            icache_rdata  <= l2_rdata;
            icache_dataOK <= 1'b1;
          end else begin
            dcache_rdata  <= l2_rdata;
            dcache_dataOK <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
